serial_word_rx: RTL and testbench

Frame-level serial receiver that consumes the bit stream captured by the edge-triggered sampling flip-flop and assembles it into parallel words. Detects start bit, shifts WIDTH data bits LSB-first, checks optional even parity and stop bit, then presents the word on a one-entry valid/ready output register. Sits directly downstream of the D flip-flop stage and upstream of any word consumer (register file, display, FIFO).

---
 rtl/serial_rx_pkg.sv | 14 +
 rtl/rx_shift_reg.sv | 37 +++
 rtl/serial_word_rx.sv | 142 ++++++++++++++
 tb/tb_serial_word_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types for the serial word receiver: FSM state encoding and default frame width.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rx_shift_reg.sv
// Right-shift register that assembles an LSB-first serial stream: each new bit
// enters at the MSB so the first bit received ends up in bit 0.
module rx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge i_clk) begin
                if (i_clear) begin
                    r_data <= '0;
                end else if (i_shift) begin
                    r_data <= i_bit;
                end
            end
        end else begin : g_multi
            always_ff @(posedge i_clk) begin
                if (i_clear) begin
                    r_data <= '0;
                end else if (i_shift) begin
                    r_data <= {i_bit, r_data[WIDTH-1:1]};
                end
            end
        end
    endgenerate

    assign o_data = r_data;

endmodule

// File: rtl/serial_word_rx.sv
// Frame-level serial receiver: start bit, WIDTH data bits LSB-first, optional even
// parity, stop bit; completed words land in a one-entry valid/ready output register.
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PARITY_EN = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             BIT_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             PERR,
    output logic             FERR,
    output logic             OVERRUN,
    output logic             BUSY
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CW-1:0]    r_count;
    logic             r_parBit;
    logic [WIDTH-1:0] w_data;
    logic             w_start;
    logic             w_shift;
    logic             w_done;
    logic             w_ferr;
    logic             w_perr;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_overrun;

    rx_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .i_clk  (CLK),
        .i_clear(RST | w_start),
        .i_shift(w_shift),
        .i_bit  (SIN),
        .o_data (w_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every transition is gated by the bit strobe; a low line in BREAK never counts as a start.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        w_ferr  = 1'b0;
        if (BIT_EN) begin
            case (r_state)
                IDLE: begin
                    if (!SIN) begin
                        w_next  = DATA;
                        w_start = 1'b1;
                    end
                end
                DATA: begin
                    w_shift = 1'b1;
                    if (r_count == LAST) begin
                        w_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: w_next = STOP;
                STOP: begin
                    w_next = SIN ? IDLE : BREAK;
                    w_done = SIN;
                    w_ferr = !SIN;
                end
                BREAK: begin
                    if (SIN) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || w_start) begin
            r_count <= '0;
        end else if (w_shift) begin
            r_count <= r_count + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_parBit <= 1'b0;
        end else if (BIT_EN && r_state == PARITY) begin
            r_parBit <= SIN;
        end
    end

    assign w_perr = (PARITY_EN != 0) ? (^w_data ^ r_parBit) : 1'b0;

    // A completing word may replace the held one only if that one leaves on this same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_done && (!r_valid || DOUT_READY)) begin
                r_dout  <= w_data;
                r_perr  <= w_perr;
                r_valid <= 1'b1;
            end else if (r_valid && DOUT_READY) begin
                r_valid <= 1'b0;
            end
            r_ferr    <= w_ferr;
            r_overrun <= w_done && r_valid && !DOUT_READY;
        end
    end

    assign DOUT       = r_dout;
    assign DOUT_VALID = r_valid;
    assign PERR       = r_perr;
    assign FERR       = r_ferr;
    assign OVERRUN    = r_overrun;
    assign BUSY       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed frames from the test plan plus
// randomized frames, compared against a frame-level model of the output register.
module tb_serial_word_rx;

    localparam int WIDTH     = 8;
    localparam int PARITY_EN = 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             sin = 1'b1;
    logic             bitEn = 1'b0;
    logic             doutReady = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             doutValid;
    logic             perr;
    logic             ferr;
    logic             overrun;
    logic             busy;

    int               checks = 0;
    int               errors = 0;
    bit               mValid = 1'b0;
    logic [WIDTH-1:0] mDout = '0;
    bit               mPerr = 1'b0;
    bit               gapSin = 1'b0;

    serial_word_rx #(
        .WIDTH(WIDTH),
        .PARITY_EN(PARITY_EN)
    ) dut (
        .CLK       (clock),
        .RST       (reset),
        .SIN       (sin),
        .BIT_EN    (bitEn),
        .DOUT      (dout),
        .DOUT_VALID(doutValid),
        .DOUT_READY(doutReady),
        .PERR      (perr),
        .FERR      (ferr),
        .OVERRUN   (overrun),
        .BUSY      (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rdyFor(input int mode, input bit isStop);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(1, 0));
            default: return isStop;
        endcase
    endfunction

    // One clock of stimulus (driven at negedge), then the model's view of the output
    // register is updated from the frame-level event and compared after the edge.
    task automatic applyStimulus(input bit s, input bit en, input bit rdy, input bit done,
                                 input bit badStop, input logic [WIDTH-1:0] word,
                                 input bit wordPerr, input bit expBusy);
        bit expOverrun;
        expOverrun = 1'b0;
        if (done) begin
            if (!mValid || rdy) begin
                mValid = 1'b1;
                mDout  = word;
                mPerr  = wordPerr;
            end else begin
                expOverrun = 1'b1;
            end
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
        sin       = s;
        bitEn     = en;
        doutReady = rdy;
        @(posedge clock);
        @(negedge clock);
        checkOutput("valid", doutValid, mValid);
        if (mValid) begin
            checkOutput("dout", dout, mDout);
            checkOutput("perr", perr, mPerr);
        end
        checkOutput("ferr", ferr, badStop);
        checkOutput("overrun", overrun, expOverrun);
        checkOutput("busy", busy, expBusy);
    endtask

    task automatic doGaps(input int n, input int mode, input bit busyNow);
        repeat (n) begin
            gapSin = ~gapSin;
            applyStimulus(gapSin, 1'b0, rdyFor(mode, 1'b0), 1'b0, 1'b0, '0, 1'b0, busyNow);
        end
    endtask

    // Full frame from idle: start, data LSB-first, parity, stop, with BIT_EN=0 gaps.
    task automatic sendFrame(input logic [WIDTH-1:0] word, input bit parBit, input bit stopBit,
                             input int gapMin, input int gapMax, input int mode);
        int nBits;
        nBits = WIDTH + PARITY_EN + 2;
        for (int i = 0; i < nBits; i++) begin
            bit s;
            bit last;
            last = (i == nBits - 1);
            if (i == 0)                                  s = 1'b0;
            else if (i <= WIDTH)                         s = word[i-1];
            else if (PARITY_EN != 0 && i == WIDTH + 1)   s = parBit;
            else                                         s = stopBit;
            doGaps(int'($urandom_range(gapMax, gapMin)), mode, i != 0);
            applyStimulus(s, 1'b1, rdyFor(mode, last), last && stopBit, last && !stopBit,
                          word, ^word ^ parBit, last ? !stopBit : 1'b1);
        end
    endtask

    task automatic holdLow(input int n, input int mode);
        repeat (n) applyStimulus(1'b0, 1'b1, rdyFor(mode, 1'b0), 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic idleStrobe(input bit rdy);
        applyStimulus(1'b1, 1'b1, rdy, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        sin       = 1'($urandom_range(1, 0));
        bitEn     = 1'($urandom_range(1, 0));
        doutReady = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        mValid = 1'b0;
        mDout  = '0;
        mPerr  = 1'b0;
        checkOutput("rst_valid", doutValid, 1'b0);
        checkOutput("rst_dout", dout, '0);
        checkOutput("rst_perr", perr, 1'b0);
        checkOutput("rst_ferr", ferr, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
    endtask

    initial begin
        @(negedge clock);
        doReset();

        // Good 0xA5 frame, then consume it.
        sendFrame(8'hA5, 1'b0, 1'b1, 0, 0, 0);
        idleStrobe(1'b1);

        // Same frame with a wrong parity bit.
        sendFrame(8'hA5, 1'b1, 1'b1, 0, 0, 0);
        idleStrobe(1'b1);

        // Framing error, line held low without restarting, then a clean frame.
        sendFrame(8'hA5, 1'b0, 1'b0, 0, 0, 0);
        holdLow(5, 0);
        idleStrobe(1'b0);
        sendFrame(8'h3C, 1'b0, 1'b1, 0, 0, 0);
        idleStrobe(1'b1);

        // Overrun: second word dropped, first retained, then drained.
        sendFrame(8'h3C, 1'b0, 1'b1, 0, 0, 0);
        sendFrame(8'hC3, 1'b0, 1'b1, 0, 0, 0);
        idleStrobe(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Ready on the completing edge frees the slot for the new word.
        sendFrame(8'h3C, 1'b0, 1'b1, 0, 0, 0);
        sendFrame(8'hC3, 1'b0, 1'b1, 0, 0, 3);
        idleStrobe(1'b1);

        // Reset mid-frame with a word held, then a slow-strobe frame.
        sendFrame(8'hA5, 1'b0, 1'b1, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'(i % 2), 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        end
        doReset();
        sendFrame(8'h5A, 1'b0, 1'b1, 3, 3, 0);
        idleStrobe(1'b1);

        // Randomized frames with random gaps, ready, parity and stop errors.
        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] w;
            bit               pb;
            bit               sb;
            w  = WIDTH'($urandom);
            pb = ^w ^ ($urandom_range(5, 0) == 0);
            sb = ($urandom_range(7, 0) != 0);
            sendFrame(w, pb, sb, 0, 2, 2);
            if (!sb) begin
                holdLow(int'($urandom_range(3, 0)), 2);
                idleStrobe(rdyFor(2, 1'b0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
